// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// Holds opcode constants, state and mux-select enums, and the opcode classifier.
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_BR_NT = 3'd5,
    S_JR    = 3'd6,
    S_HALT  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } src_b_e;

  localparam logic SRC_A_PC      = 1'b0;
  localparam logic SRC_A_REG     = 1'b1;
  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  typedef enum logic [3:0] {
    OPC_R, OPC_I_ALU, OPC_LOAD, OPC_STORE, OPC_BRANCH,
    OPC_JAL, OPC_JALR, OPC_ECALL, OPC_ILLEGAL
  } opclass_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    i_or_d;
    logic    ir_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    pc_write;
    logic    pc_source;
  } ctrl_t;

  function automatic opclass_e classify(input logic [6:0] op);
    case (op)
      OP_R:      return OPC_R;
      OP_I_ALU:  return OPC_I_ALU;
      OP_LOAD:   return OPC_LOAD;
      OP_STORE:  return OPC_STORE;
      OP_BRANCH: return OPC_BRANCH;
      OP_JAL:    return OPC_JAL;
      OP_JALR:   return OPC_JALR;
      OP_SYSTEM: return OPC_ECALL;
      default:   return OPC_ILLEGAL;
    endcase
  endfunction

  // Where ID goes: S_IF means "retire as a NOP", bumping PC by 4 from ID.
  function automatic state_e id_next(input opclass_e opc, input logic halt_req,
                                     input bit halt_on_illegal, input bit ecall_halt_en);
    if (opc == OPC_ECALL)   return (ecall_halt_en && halt_req) ? S_HALT : S_IF;
    if (opc == OPC_ILLEGAL) return halt_on_illegal ? S_HALT : S_IF;
    return S_EX;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode for the multi-cycle FSM.
// Maps (state, opcode, branch result, memory ready, halt request) to datapath controls.
module mc_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit ECALL_HALT_EN   = 1'b1
) (
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_alu_bcond,
  input  logic       i_halt_req,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  opclass_e w_opc;

  always_comb begin
    // NOTE: assigning every output a default first keeps this block latch-free.
    o_ctrl = '0;
    w_opc  = classify(i_opcode);
    case (i_state)
      S_IF: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ir_write = i_mem_ready;
      end
      S_ID: begin
        if (id_next(w_opc, i_halt_req, HALT_ON_ILLEGAL, ECALL_HALT_EN) == S_IF) begin
          o_ctrl.alu_src_a = SRC_A_PC;
          o_ctrl.alu_src_b = SRC_B_FOUR;
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PC_SRC_ALU;
        end else begin
          o_ctrl.alu_src_a = SRC_A_PC;
          o_ctrl.alu_src_b = SRC_B_IMM;
          o_ctrl.alu_op    = ALU_ADD;
        end
      end
      S_EX: begin
        case (w_opc)
          OPC_R: begin
            o_ctrl.alu_src_a = SRC_A_REG;
            o_ctrl.alu_src_b = SRC_B_REG;
            o_ctrl.alu_op    = ALU_RFUNCT;
          end
          OPC_I_ALU: begin
            o_ctrl.alu_src_a = SRC_A_REG;
            o_ctrl.alu_src_b = SRC_B_IMM;
            o_ctrl.alu_op    = ALU_IFUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            o_ctrl.alu_src_a = SRC_A_REG;
            o_ctrl.alu_src_b = SRC_B_IMM;
          end
          OPC_BRANCH: begin
            o_ctrl.alu_src_a = SRC_A_REG;
            o_ctrl.alu_src_b = SRC_B_REG;
            o_ctrl.alu_op    = ALU_BRANCH;
            o_ctrl.pc_write  = i_alu_bcond;
            o_ctrl.pc_source = i_alu_bcond ? PC_SRC_ALUOUT : PC_SRC_ALU;
          end
          // ALUOut still holds PC+imm from ID, so the jump target comes from it.
          OPC_JAL: begin
            o_ctrl.alu_src_b = SRC_B_FOUR;
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PC_SRC_ALUOUT;
          end
          OPC_JALR: o_ctrl.alu_src_b = SRC_B_FOUR;
          default: ;
        endcase
      end
      S_MEM: begin
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.mem_read  = (w_opc == OPC_LOAD);
        o_ctrl.mem_write = (w_opc == OPC_STORE);
        if (w_opc == OPC_STORE && i_mem_ready) begin
          o_ctrl.alu_src_b = SRC_B_FOUR;
          o_ctrl.pc_write  = 1'b1;
        end
      end
      S_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = (w_opc == OPC_LOAD);
        if (w_opc != OPC_JAL) begin
          o_ctrl.alu_src_b = SRC_B_FOUR;
          o_ctrl.pc_write  = 1'b1;
        end
      end
      S_BR_NT: begin
        o_ctrl.alu_src_b = SRC_B_FOUR;
        o_ctrl.pc_write  = 1'b1;
      end
      S_JR: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src_a = SRC_A_REG;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing FSM: state register, next-state logic and sticky halt.
// Control outputs come from mc_ctrl_decode and are held at zero while reset is high.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit ECALL_HALT_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_source,
  output logic       is_halted,
  output logic [2:0] state_dbg
);

  state_e   r_state;
  state_e   w_next;
  logic     r_is_halted;
  opclass_e w_opc;
  ctrl_t    w_ctrl;
  ctrl_t    w_ctrl_out;

  mc_ctrl_decode #(
    .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL),
    .ECALL_HALT_EN   (ECALL_HALT_EN)
  ) u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_alu_bcond (alu_bcond),
    .i_halt_req  (halt_req),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  always_comb begin
    w_next = r_state;
    w_opc  = classify(opcode);
    case (r_state)
      S_IF:  w_next = mem_ready ? S_ID : S_IF;
      S_ID:  w_next = id_next(w_opc, halt_req, HALT_ON_ILLEGAL, ECALL_HALT_EN);
      S_EX: begin
        case (w_opc)
          OPC_R, OPC_I_ALU, OPC_JAL: w_next = S_WB;
          OPC_LOAD, OPC_STORE:       w_next = S_MEM;
          OPC_BRANCH:                w_next = alu_bcond ? S_IF : S_BR_NT;
          OPC_JALR:                  w_next = S_JR;
          default:                   w_next = S_IF;
        endcase
      end
      S_MEM: begin
        if (mem_ready) w_next = (w_opc == OPC_LOAD) ? S_WB : S_IF;
      end
      S_WB, S_BR_NT, S_JR: w_next = S_IF;
      S_HALT:              w_next = S_HALT;
      default:             w_next = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IF;
      r_is_halted <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_is_halted <= r_is_halted | (w_next == S_HALT);
    end
  end

  // Reset gates the decode directly so a pending memory write drops immediately.
  assign w_ctrl_out = reset ? '0 : w_ctrl;

  assign mem_read   = w_ctrl_out.mem_read;
  assign mem_write  = w_ctrl_out.mem_write;
  assign i_or_d     = w_ctrl_out.i_or_d;
  assign ir_write   = w_ctrl_out.ir_write;
  assign reg_write  = w_ctrl_out.reg_write;
  assign mem_to_reg = w_ctrl_out.mem_to_reg;
  assign alu_src_a  = w_ctrl_out.alu_src_a;
  assign alu_src_b  = w_ctrl_out.alu_src_b;
  assign alu_op     = w_ctrl_out.alu_op;
  assign pc_write   = w_ctrl_out.pc_write;
  assign pc_source  = w_ctrl_out.pc_source;
  assign is_halted  = r_is_halted;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
// Control word layout: {rd,wr,iord,irw,regw,m2r,srca}_{srcb}_{aluop}_{pcw,pcs}.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_req;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg;
  logic       alu_src_a, pc_write, pc_source, is_halted;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  localparam logic [12:0] C_ZERO    = 13'b0000000_00_00_00;
  localparam logic [12:0] C_IF_W    = 13'b1000000_00_00_00;
  localparam logic [12:0] C_IF_R    = 13'b1001000_00_00_00;
  localparam logic [12:0] C_ID      = 13'b0000000_10_00_00;
  localparam logic [12:0] C_ID_SKIP = 13'b0000000_01_00_10;
  localparam logic [12:0] C_EX_R    = 13'b0000001_00_10_00;
  localparam logic [12:0] C_EX_I    = 13'b0000001_10_11_00;
  localparam logic [12:0] C_EX_LS   = 13'b0000001_10_00_00;
  localparam logic [12:0] C_EX_BT   = 13'b0000001_00_01_11;
  localparam logic [12:0] C_EX_BN   = 13'b0000001_00_01_00;
  localparam logic [12:0] C_EX_JAL  = 13'b0000000_01_00_11;
  localparam logic [12:0] C_EX_JALR = 13'b0000000_01_00_00;
  localparam logic [12:0] C_MEM_LD  = 13'b1010000_00_00_00;
  localparam logic [12:0] C_MEM_SW  = 13'b0110000_00_00_00;
  localparam logic [12:0] C_MEM_SR  = 13'b0110000_01_00_10;
  localparam logic [12:0] C_WB_ALU  = 13'b0000100_01_00_10;
  localparam logic [12:0] C_WB_LD   = 13'b0000110_01_00_10;
  localparam logic [12:0] C_WB_JAL  = 13'b0000100_00_00_00;
  localparam logic [12:0] C_BRNT    = 13'b0000000_01_00_10;
  localparam logic [12:0] C_JR      = 13'b0000101_10_00_10;

  localparam logic [6:0] OPC_ADD  = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;
  localparam logic [6:0] OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_ECL  = 7'h73;
  localparam logic [6:0] OPC_LUI  = 7'h37;

  wire [12:0] ctrl_obs = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg,
                          alu_src_a, alu_src_b, alu_op, pc_write, pc_source};

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .alu_bcond  (alu_bcond),
    .halt_req   (halt_req),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .is_halted  (is_halted),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: inputs already driven; sample at the falling edge, then advance.
  task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [12:0] exp_ctrl);
    @(negedge clk);
    check({tag, ".state"}, 16'(state_dbg), 16'(exp_state));
    check({tag, ".ctrl"}, 16'(ctrl_obs), 16'(exp_ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = OPC_ADD; alu_bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset_hold", 3'd0, C_ZERO);
    check("reset_halt", 16'(is_halted), 16'd0);
    reset = 1'b0;

    // add: IF ID EX WB, single pc_write in WB with pc_source=0
    cyc("add_if", 3'd0, C_IF_R);
    cyc("add_id", 3'd1, C_ID);
    cyc("add_ex", 3'd2, C_EX_R);
    cyc("add_wb", 3'd4, C_WB_ALU);

    // lw with three wait cycles in MEM: 8 cycles total
    opcode = OPC_LW;
    cyc("lw_if", 3'd0, C_IF_R);
    cyc("lw_id", 3'd1, C_ID);
    cyc("lw_ex", 3'd2, C_EX_LS);
    mem_ready = 1'b0;
    cyc("lw_mem_w0", 3'd3, C_MEM_LD);
    cyc("lw_mem_w1", 3'd3, C_MEM_LD);
    cyc("lw_mem_w2", 3'd3, C_MEM_LD);
    mem_ready = 1'b1;
    cyc("lw_mem_rdy", 3'd3, C_MEM_LD);
    cyc("lw_wb", 3'd4, C_WB_LD);

    // addi: IF stall, and mem_ready low outside IF/MEM is ignored
    opcode = OPC_ADDI; mem_ready = 1'b0;
    cyc("addi_if_wait", 3'd0, C_IF_W);
    mem_ready = 1'b1;
    cyc("addi_if", 3'd0, C_IF_R);
    mem_ready = 1'b0;
    cyc("addi_id", 3'd1, C_ID);
    cyc("addi_ex", 3'd2, C_EX_I);
    cyc("addi_wb", 3'd4, C_WB_ALU);
    mem_ready = 1'b1;

    // beq taken: back to IF right after EX
    opcode = OPC_BEQ; alu_bcond = 1'b1;
    cyc("beqt_if", 3'd0, C_IF_R);
    cyc("beqt_id", 3'd1, C_ID);
    cyc("beqt_ex", 3'd2, C_EX_BT);

    // beq not taken: through BR_NT
    alu_bcond = 1'b0;
    cyc("beqn_if", 3'd0, C_IF_R);
    cyc("beqn_id", 3'd1, C_ID);
    cyc("beqn_ex", 3'd2, C_EX_BN);
    cyc("beqn_brnt", 3'd5, C_BRNT);

    // jal: PC written in EX, WB writes rd only
    opcode = OPC_JAL;
    cyc("jal_if", 3'd0, C_IF_R);
    cyc("jal_id", 3'd1, C_ID);
    cyc("jal_ex", 3'd2, C_EX_JAL);
    cyc("jal_wb", 3'd4, C_WB_JAL);

    // jalr: EX has no writes, JR writes rd and PC together
    opcode = OPC_JALR;
    cyc("jalr_if", 3'd0, C_IF_R);
    cyc("jalr_id", 3'd1, C_ID);
    cyc("jalr_ex", 3'd2, C_EX_JALR);
    cyc("jalr_jr", 3'd6, C_JR);

    // sw with one wait cycle
    opcode = OPC_SW;
    cyc("sw_if", 3'd0, C_IF_R);
    cyc("sw_id", 3'd1, C_ID);
    cyc("sw_ex", 3'd2, C_EX_LS);
    mem_ready = 1'b0;
    cyc("sw_mem_w", 3'd3, C_MEM_SW);
    mem_ready = 1'b1;
    cyc("sw_mem_rdy", 3'd3, C_MEM_SR);

    // ecall without halt request retires as NOP in ID
    opcode = OPC_ECL; halt_req = 1'b0;
    cyc("ecall_nop_if", 3'd0, C_IF_R);
    cyc("ecall_nop_id", 3'd1, C_ID_SKIP);

    // illegal opcode halts after ID
    opcode = OPC_LUI;
    cyc("illeg_if", 3'd0, C_IF_R);
    check("illeg_pre_halt", 16'(is_halted), 16'd0);
    cyc("illeg_id", 3'd1, C_ID);
    cyc("illeg_halt", 3'd7, C_ZERO);
    check("illeg_is_halted", 16'(is_halted), 16'd1);

    // reset from HALT, then reset asserted in the middle of a store wait
    reset = 1'b1;
    #1;
    check("halt_reset_flag", 16'(is_halted), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    opcode = OPC_SW;
    cyc("rst_sw_if", 3'd0, C_IF_R);
    cyc("rst_sw_id", 3'd1, C_ID);
    cyc("rst_sw_ex", 3'd2, C_EX_LS);
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_sw_mem_state", 16'(state_dbg), 16'd3);
    check("rst_sw_mem_write", 16'(mem_write), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ctrl", 16'(ctrl_obs), 16'(C_ZERO));
    check("rst_mid_state", 16'(state_dbg), 16'd0);
    check("rst_mid_halted", 16'(is_halted), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    cyc("post_rst_if", 3'd0, C_IF_R);
    check("post_rst_halted", 16'(is_halted), 16'd0);

    // ecall with halt request: HALT absorbs opcode and mem_ready changes
    opcode = OPC_ECL; halt_req = 1'b1;
    cyc("ecall_halt_id", 3'd1, C_ID);
    for (int i = 0; i < 20; i++) begin
      opcode    = (i % 2 == 0) ? OPC_ADD : OPC_SW;
      mem_ready = i[0];
      halt_req  = i[1];
      alu_bcond = i[2];
      @(negedge clk);
      check("halt_state", 16'(state_dbg), 16'd7);
      check("halt_ctrl", 16'(ctrl_obs), 16'(C_ZERO));
      check("halt_flag", 16'(is_halted), 16'd1);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
